branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the 5-stage MIPS pipeline.
//  Sits in IF beside the PC adder and steers the next-PC mux with a predicted target.
//  ID-stage branch resolution trains it through the update port.
//  Adds speculative next-PC prediction; today's pipeline resolves every branch in ID and flushes IF/ID when taken.
// PARAMETERS
//  ENTRIES  16  BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
//  PC_W     32  PC width; tag = pc[PC_W-1:IDX_W+2], index = pc[IDX_W+1:2]
//  CNT_W    16  width of each statistics counter
// PORTS
//  clk              in   1     clock; all state updates on rising edge
//  reset            in   1     synchronous, active-high
//  lookup_pc        in   PC_W  IF-stage PC (readPC)
//  pred_hit         out  1     valid entry with matching tag at lookup_pc
//  pred_taken       out  1     pred_hit && counter[1]
//  pred_target      out  PC_W  pred_taken ? stored target : lookup_pc+4
//  flush            in   1     clear all valid bits (instruction memory reload)
//  upd_valid        in   1     ID resolved a branch this cycle
//  upd_pc           in   PC_W  PC of the resolved branch
//  upd_taken        in   1     actual outcome
//  upd_target       in   PC_W  actual taken target (branchAddress)
//  upd_mispredict   in   1     IF prediction for this branch was wrong
//  stat_hits        out  CNT_W lookups with pred_hit=1, saturating
//  stat_mispredicts out  CNT_W upd_valid&&upd_mispredict events, saturating
// BEHAVIOUR
//  - Lookup is combinational from registered arrays, zero latency. Bits [1:0] of every PC are ignored.
//  - Reset: all valid=0, all counters=2'b01 (weakly not-taken), stats=0.
//    pred_hit=0, pred_taken=0 and pred_target=lookup_pc+4 in the cycle after reset.
//  - Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Only WT/ST predict taken.
//  - Update when upd_valid=1, at the rising edge:
//    * Tag hit: counter +1 if taken (saturates at 11), -1 if not taken (saturates at 00).
//      Target rewritten only when taken.
//    * Tag miss and taken: allocate or replace the entry at index. valid=1, tag, target, counter=2'b10.
//    * Tag miss and not taken: no change (no allocation).
//  - Same-cycle lookup and update to the same index: lookup returns the pre-update value (read-old).
//    The new value is visible the next cycle.
//  - Priority: reset > flush > update. A flush cycle clears valids and discards that cycle's update.
//    Counters and targets are kept, but are unreachable until reallocated.
//  - flush does not clear stats. Stats saturate at all-ones and never wrap.
//  - stat_hits increments once per cycle with pred_hit=1 and reset=0.
//  - Reset mid-operation discards any in-flight update. No state from before reset survives.
//  - PC+4 arithmetic is modulo 2^PC_W; wrap-around at the top of memory is legal.
// STRUCTURE
//  - Shared package mips_pkg:
//    * localparams CTR_SNT/CTR_WNT/CTR_WT/CTR_ST
//    * the function next_ctr(ctr, taken)
//    * PC_W default
//  - Arrays: valid[ENTRIES] flops; tag, target and ctr as register arrays with synchronous write, asynchronous read.
//  - One sub-module: sat_counter (parametrised width, inc/dec enables, saturating).
//    Used for both statistics counters.
// TESTING
//  1. Reset, then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44; stats=0.
//  2. upd pc=0x40 taken target=0x80 -> next cycle lookup 0x40: hit=1, taken=1 (ctr 10), target=0x80.
//  3. Two not-taken updates at 0x40 -> ctr 10->01->00; lookup gives hit=1, taken=0, target=0x44.
//     Third not-taken update: ctr stays 00.
//  4. ENTRIES=16: alias 0x40 vs 0x80: taken upd at 0x80 target 0x100 replaces the entry.
//     Lookup 0x40 then gives hit=0; not-taken upd at an empty index allocates nothing.
//  5. Same-cycle lookup+update at 0x40 -> old value this cycle, new value next cycle.
//     flush together with upd -> all hits 0 next cycle and the update is dropped.
//  6. Force stat_mispredicts to 0xFFFF (CNT_W=16) and apply one more mispredict -> stays 0xFFFF.
//     reset mid-update -> all outputs return to reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: default PC width, 2-bit direction
// counter encodings and the saturating counter step function.
package mips_pkg;

  localparam int DEF_PC_W = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] next_ctr(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] r;
    r = ctr;
    if (taken && ctr != CTR_ST)
      r = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT)
      r = ctr - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Predictor bus: IF lookup, ID update/flush, statistics.
// master = pipeline side, slave = predictor side.
interface branch_target_predictor_if
  import mips_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  lookup_pc;
  logic             pred_hit;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             flush;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_mispredict;
  logic [CNT_W-1:0] stat_hits;
  logic [CNT_W-1:0] stat_mispredicts;

  modport master (
    output lookup_pc, flush, upd_valid, upd_pc,
    output upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target,
    input  stat_hits, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, flush, upd_valid, upd_pc,
    input  upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target,
    output stat_hits, stat_mispredicts
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter; holds at all-ones and at zero.
// Ports: clk, reset (sync, high), inc, dec, count.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && !dec && count != '1)
      count <= count + W'(1);
    else if (dec && !inc && count != '0)
      count <= count - W'(1);
  end

endmodule

// File: rtl/branch_target_predictor.sv
// BTB with 2-bit direction counters; zero-latency lookup, ID-stage training.
// Ports: clk, reset (sync, high), bus (slave: lookup/pred/update/flush/stats).
module branch_target_predictor
  import mips_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = DEF_PC_W,
  parameter int CNT_W   = 16
) (
  input logic                   clk,
  input logic                   reset,
  branch_target_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             do_upd;
  logic             hit;
  logic             taken;

  wire unused_low = &{1'b0, bus.upd_pc[1:0]};

  assign l_idx = bus.lookup_pc[IDX_W+1:2];
  assign l_tag = bus.lookup_pc[PC_W-1:IDX_W+2];
  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[PC_W-1:IDX_W+2];

  // Reads see registered state only, so a same-cycle update is
  // invisible until the following cycle.
  assign hit   = valid[l_idx] && (tag_q[l_idx] == l_tag);
  assign taken = hit && ctr_q[l_idx][1];

  assign bus.pred_hit    = hit;
  assign bus.pred_taken  = taken;
  assign bus.pred_target = taken ? tgt_q[l_idx]
                                 : bus.lookup_pc + PC_W'(4);

  assign u_hit  = valid[u_idx] && (tag_q[u_idx] == u_tag);
  assign do_upd = bus.upd_valid && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset)
      valid <= '0;
    else if (bus.flush)
      valid <= '0;
    else if (do_upd && bus.upd_taken)
      valid[u_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= CTR_WNT;
    end else if (do_upd) begin
      if (u_hit)
        ctr_q[u_idx] <= next_ctr(ctr_q[u_idx], bus.upd_taken);
      else if (bus.upd_taken)
        ctr_q[u_idx] <= CTR_WT;
    end
  end

  // Tag and target need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!reset && do_upd && bus.upd_taken) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= bus.upd_target;
    end
  end

  sat_counter #(.W(CNT_W)) u_hits (
    .clk   (clk),
    .reset (reset),
    .inc   (hit),
    .dec   (1'b0),
    .count (bus.stat_hits)
  );

  sat_counter #(.W(CNT_W)) u_misp (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.upd_valid && bus.upd_mispredict),
    .dec   (1'b0),
    .count (bus.stat_mispredicts)
  );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: directed scenarios
// plus random traffic against a table-based reference model.
module tb_branch_target_predictor;
  import mips_pkg::*;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int PC_W    = 32;
  localparam int CNT_W   = 8;
  localparam int SMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_target_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bif ();

  branch_target_predictor #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    int          sh;
    int          sm;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Reference model: one record per BTB slot.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_sh;
  int          m_sm;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_ctr[i] = 1;
    end
    m_sh = 0;
    m_sm = 0;
  endtask

  task automatic cyc(
    input logic [31:0] pc,
    input bit          fl,
    input bit          uv,
    input logic [31:0] upc,
    input bit          ut,
    input logic [31:0] utgt,
    input bit          mis,
    input bit          rs
  );
    exp_t e;
    int i;
    int u;
    @(posedge clk);
    #1;
    bif.lookup_pc      = pc;
    bif.flush          = fl;
    bif.upd_valid      = uv;
    bif.upd_pc         = upc;
    bif.upd_taken      = ut;
    bif.upd_target     = utgt;
    bif.upd_mispredict = mis;
    reset              = rs;
    i = idx_of(pc);
    e.hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
    e.taken = e.hit && (m_ctr[i] >= 2);
    e.tgt   = e.taken ? m_tgt[i] : pc + 32'd4;
    e.sh    = m_sh;
    e.sm    = m_sm;
    q.push_back(e);
    if (rs) begin
      model_reset();
    end else begin
      if (e.hit && m_sh < SMAX) m_sh++;
      if (uv && mis && m_sm < SMAX) m_sm++;
      if (fl) begin
        for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
      end else if (uv) begin
        u = idx_of(upc);
        if (m_valid[u] && m_tag[u] == tag_of(upc)) begin
          if (ut) begin
            m_ctr[u] = (m_ctr[u] < 3) ? m_ctr[u] + 1 : 3;
            m_tgt[u] = utgt;
          end else begin
            m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
          end
        end else if (ut) begin
          m_valid[u] = 1;
          m_tag[u]   = tag_of(upc);
          m_tgt[u]   = utgt;
          m_ctr[u]   = 2;
        end
      end
    end
  endtask

  task automatic lk(input logic [31:0] pc);
    cyc(pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic up(
    input logic [31:0] pc,
    input logic [31:0] upc,
    input bit          ut,
    input logic [31:0] utgt,
    input bit          mis
  );
    cyc(pc, 0, 1, upc, ut, utgt, mis, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_chk += 5;
      if (bif.pred_hit !== e.hit) begin
        n_fail++;
        $display("FAIL hit pc=%h got %b want %b",
                 bif.lookup_pc, bif.pred_hit, e.hit);
      end
      if (bif.pred_taken !== e.taken) begin
        n_fail++;
        $display("FAIL taken pc=%h got %b want %b",
                 bif.lookup_pc, bif.pred_taken, e.taken);
      end
      if (bif.pred_target !== e.tgt) begin
        n_fail++;
        $display("FAIL target pc=%h got %h want %h",
                 bif.lookup_pc, bif.pred_target, e.tgt);
      end
      if (int'(bif.stat_hits) != e.sh || $isunknown(bif.stat_hits)) begin
        n_fail++;
        $display("FAIL stat_hits got %0d want %0d",
                 bif.stat_hits, e.sh);
      end
      if (int'(bif.stat_mispredicts) != e.sm ||
          $isunknown(bif.stat_mispredicts)) begin
        n_fail++;
        $display("FAIL stat_mispredicts got %0d want %0d",
                 bif.stat_mispredicts, e.sm);
      end
    end
  end

  function automatic logic [31:0] rnd_pc();
    logic [31:0] t;
    logic [31:0] ix;
    t  = 32'($urandom_range(0, 3));
    ix = 32'($urandom_range(0, ENTRIES - 1));
    return (t << (IDX_W + 2)) | (ix << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    reset              = 1'b1;
    bif.lookup_pc      = '0;
    bif.flush          = 1'b0;
    bif.upd_valid      = 1'b0;
    bif.upd_pc         = '0;
    bif.upd_taken      = 1'b0;
    bif.upd_target     = '0;
    bif.upd_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    lk(32'h40);
    up(32'h0, 32'h40, 1, 32'h80, 0);
    lk(32'h40);
    up(32'h40, 32'h40, 0, 0, 1);
    up(32'h40, 32'h40, 0, 0, 1);
    lk(32'h40);
    up(32'h40, 32'h40, 0, 0, 0);
    lk(32'h40);
    up(32'h40, 32'h80, 1, 32'h100, 1);
    lk(32'h40);
    lk(32'h80);
    up(32'h44, 32'h44, 0, 0, 0);
    lk(32'h44);
    up(32'h80, 32'h80, 1, 32'h200, 0);
    lk(32'h80);
    cyc(32'h80, 1, 1, 32'h48, 1, 32'h300, 1, 0);
    lk(32'h80);
    lk(32'h48);
    up(32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h0, 0);
    lk(32'hFFFF_FFFC);
    lk(32'hFFFF_FFFD);
    for (int n = 0; n < SMAX + 8; n++)
      up(32'h40, 32'h40, 0, 0, 1);
    lk(32'h40);
    cyc(32'h40, 0, 1, 32'h40, 1, 32'h500, 1, 1);
    lk(32'h40);
    lk(32'hFFFF_FFFC);

    for (int n = 0; n < 3000; n++) begin
      cyc(rnd_pc(),
          $urandom_range(0, 29) == 0,
          $urandom_range(0, 1) == 1,
          rnd_pc(),
          $urandom_range(0, 2) != 0,
          $urandom,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 199) == 0);
    end

    for (int w = 0; w < 4 && q.size() != 0; w++)
      @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d left want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
